int_req_arbiter: RTL and testbench

//  Front end of the interrupt path, directly upstream of the interrupt controller.

---
 rtl/int_req_arbiter_pkg.sv | 45 ++++
 rtl/int_req_arbiter_sync.sv | 27 ++
 rtl/int_req_arbiter.sv | 132 +++++++++++++
 tb/tb_int_req_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_req_arbiter_pkg.sv
// Shared types and helpers for the interrupt request arbiter: state encoding,
// source count and the priority helper functions.
package int_req_arbiter_pkg;

    localparam int NSRC   = 4;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_FIRE = 2'd2
    } arb_state_e;

    function automatic logic is_onehot(input logic [NSRC-1:0] v);
        return (v != {NSRC{1'b0}}) && ((v & (v - {{(NSRC-1){1'b0}}, 1'b1})) == {NSRC{1'b0}});
    endfunction

    // Sources strictly above the highest in-service level; all sources when nothing is in service.
    function automatic logic [NSRC-1:0] above_mask(input logic [NSRC-1:0] insvc);
        logic [NSRC-1:0] m;
        m = {NSRC{1'b1}};
        for (int i = 0; i < NSRC; i++) begin
            if (insvc[i]) begin
                m = {NSRC{1'b1}} << (i + 1);
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    function automatic logic [CODE_W-1:0] top_idx(input logic [NSRC-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_req_arbiter_sync.sv
// Per-line synchroniser followed by a rising-edge detector on the synchronised level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_CLK,
    input  logic in_RST,
    input  logic irq_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one delayed copy of its last stage for edge detection.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_req_arbiter.sv
// Interrupt front end: latches synchronised rising edges, masks them, and arbitrates
// with nesting to issue a one-cycle break plus a stable source code.
module int_req_arbiter
    import int_req_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COOL_CYCLES = 2
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic [NSRC-1:0]   in_irq,
    input  logic              in_NIE,
    input  logic [NSRC-1:0]   in_IG,
    input  logic              in_hold,
    input  logic              in_mask_we,
    input  logic [NSRC-1:0]   in_mask_wdata,
    output logic              out_BK,
    output logic [CODE_W-1:0] out_code,
    output logic [NSRC-1:0]   out_pending,
    output logic [NSRC-1:0]   out_inservice,
    output logic [NSRC-1:0]   out_mask
);

    localparam int COOL_W = (COOL_CYCLES < 1) ? 1 : $clog2(COOL_CYCLES + 1);

    arb_state_e          state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                bk_q, bk_d;
    logic [NSRC-1:0]     pending_q, pending_d;
    logic [NSRC-1:0]     inservice_q, inservice_d;
    logic [NSRC-1:0]     mask_q, mask_d;
    logic [COOL_W-1:0]   cool_q, cool_d;

    logic [NSRC-1:0]     rise_s;
    logic [NSRC-1:0]     eligible_s;
    logic [NSRC-1:0]     fire_set_s;
    logic [NSRC-1:0]     ig_clr_s;
    logic                ig_valid_s;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .in_CLK (in_CLK),
            .in_RST (in_RST),
            .irq_i  (in_irq[g]),
            .rise_o (rise_s[g])
        );
    end

    assign eligible_s = pending_q & mask_q & above_mask(inservice_q);

    // Next-state, code latch and break decision.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        bk_d       = 1'b0;
        fire_set_s = {NSRC{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if ((cool_q == {COOL_W{1'b0}}) && in_NIE && (|eligible_s)) begin
                    state_d = ST_ARM;
                    code_d  = top_idx(eligible_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                // A newly eligible higher source does not preempt an armed one.
                if (!eligible_s[code_q]) begin
                    state_d = ST_IDLE;
                end else if (!in_hold && in_NIE) begin
                    state_d = ST_FIRE;
                    bk_d    = 1'b1;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_FIRE: begin
                state_d    = ST_IDLE;
                fire_set_s = {{(NSRC-1){1'b0}}, 1'b1} << code_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending/in-service bookkeeping, mask register and cool-down counter.
    always_comb begin
        ig_valid_s  = is_onehot(in_IG);
        ig_clr_s    = ig_valid_s ? (in_IG & inservice_q) : {NSRC{1'b0}};
        pending_d   = (pending_q & ~fire_set_s) | rise_s;
        inservice_d = (inservice_q & ~ig_clr_s) | fire_set_s;
        mask_d      = in_mask_we ? in_mask_wdata : mask_q;
        if ((fire_set_s != {NSRC{1'b0}}) || ig_valid_s) begin
            cool_d = COOL_W'(COOL_CYCLES);
        end else if (cool_q != {COOL_W{1'b0}}) begin
            cool_d = cool_q - {{(COOL_W-1){1'b0}}, 1'b1};
        end else begin
            cool_d = cool_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state_q     <= ST_IDLE;
            code_q      <= {CODE_W{1'b0}};
            bk_q        <= 1'b0;
            pending_q   <= {NSRC{1'b0}};
            inservice_q <= {NSRC{1'b0}};
            mask_q      <= {NSRC{1'b1}};
            cool_q      <= {COOL_W{1'b0}};
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            bk_q        <= bk_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            mask_q      <= mask_d;
            cool_q      <= cool_d;
        end
    end

    assign out_BK        = bk_q;
    assign out_code      = code_q;
    assign out_pending   = pending_q;
    assign out_inservice = inservice_q;
    assign out_mask      = mask_q;

endmodule

// File: tb/tb_int_req_arbiter.sv
// Directed bench: expected break codes are queued at stimulus time and a monitor
// pops one per observed out_BK cycle; register views are checked directly.
module tb_int_req_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] irq;
    logic       nie;
    logic [3:0] ig;
    logic       hold;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       bk;
    logic [1:0] code;
    logic [3:0] pending;
    logic [3:0] inservice;
    logic [3:0] mask;

    int total;
    int bad;
    logic [1:0] exp_q[$];

    int_req_arbiter #(
        .SYNC_STAGES (2),
        .COOL_CYCLES (2)
    ) dut (
        .in_CLK        (clk),
        .in_RST        (rst),
        .in_irq        (irq),
        .in_NIE        (nie),
        .in_IG         (ig),
        .in_hold       (hold),
        .in_mask_we    (mask_we),
        .in_mask_wdata (mask_wdata),
        .out_BK        (bk),
        .out_code      (code),
        .out_pending   (pending),
        .out_inservice (inservice),
        .out_mask      (mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every BK cycle must match the next queued code.
    always @(negedge clk) begin
        if (!rst && bk === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bk: got code %0d expected no break at %0t", code, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (code !== e) begin
                    bad++;
                    $display("FAIL bk_code: got %0d expected %0d at %0t", code, e, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ig(input logic [3:0] v);
        ig = v;
        tick(1);
        ig = 4'b0000;
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick(1);
        mask_we    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        irq = 4'b0000;
        nie = 1'b1;
        ig = 4'b0000;
        hold = 1'b0;
        mask_we = 1'b0;
        mask_wdata = 4'b0000;

        tick(2);
        chk("rst_pending", {4'h0, pending}, 8'h00);
        chk("rst_inservice", {4'h0, inservice}, 8'h00);
        chk("rst_mask", {4'h0, mask}, 8'h0f);
        chk("rst_bk", {7'h00, bk}, 8'h00);
        chk("rst_code", {6'h00, code}, 8'h00);
        rst = 1'b0;

        // Single source, exact timing from the raw rise.
        irq = 4'b0010;
        exp_q.push_back(2'd1);
        tick(3);
        chk("single_pending", {4'h0, pending}, 8'h02);
        tick(1);
        chk("single_arm_code", {6'h00, code}, 8'h01);
        chk("single_arm_nobk", {7'h00, bk}, 8'h00);
        tick(1);
        chk("single_bk", {7'h00, bk}, 8'h01);
        tick(1);
        chk("single_insvc", {4'h0, inservice}, 8'h02);
        chk("single_pend_clr", {4'h0, pending}, 8'h00);
        chk("single_bk_one", {7'h00, bk}, 8'h00);
        irq = 4'b0000;
        pulse_ig(4'b0010);
        tick(4);

        // Priority: source 2 before source 0; 0 waits for eret plus cool-down.
        irq = 4'b0101;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        tick(12);
        chk("prio_pending", {4'h0, pending}, 8'h01);
        chk("prio_insvc", {4'h0, inservice}, 8'h04);
        pulse_ig(4'b0100);
        tick(3);
        chk("prio_cool_nobk", {7'h00, bk}, 8'h00);
        tick(1);
        chk("prio_cool_bk", {7'h00, bk}, 8'h01);
        tick(2);
        chk("prio_insvc0", {4'h0, inservice}, 8'h01);
        pulse_ig(4'b0001);
        irq = 4'b0000;
        tick(4);

        // Nesting.
        irq = 4'b0010;
        exp_q.push_back(2'd1);
        tick(7);
        chk("nest_insvc1", {4'h0, inservice}, 8'h02);
        irq = 4'b1010;
        exp_q.push_back(2'd3);
        tick(7);
        chk("nest_insvc31", {4'h0, inservice}, 8'h0a);
        pulse_ig(4'b1000);
        irq = 4'b1011;
        tick(10);
        chk("nest_low_pending", {4'h0, pending}, 8'h01);
        chk("nest_low_insvc", {4'h0, inservice}, 8'h02);
        exp_q.push_back(2'd0);
        pulse_ig(4'b0010);
        tick(6);
        chk("nest_low_served", {4'h0, inservice}, 8'h01);
        pulse_ig(4'b0001);
        irq = 4'b0000;
        tick(4);

        // Hold while armed.
        hold = 1'b1;
        irq = 4'b0100;
        exp_q.push_back(2'd2);
        tick(4);
        for (int i = 0; i < 5; i++) begin
            chk("hold_code", {6'h00, code}, 8'h02);
            chk("hold_nobk", {7'h00, bk}, 8'h00);
            tick(1);
        end
        hold = 1'b0;
        tick(1);
        chk("hold_release_bk", {7'h00, bk}, 8'h01);
        tick(2);
        pulse_ig(4'b0100);
        irq = 4'b0000;
        tick(4);

        // Global enable low blocks new fires.
        nie = 1'b0;
        irq = 4'b1000;
        tick(10);
        chk("nie_pending", {4'h0, pending}, 8'h08);
        chk("nie_insvc", {4'h0, inservice}, 8'h00);
        exp_q.push_back(2'd3);
        nie = 1'b1;
        tick(2);
        chk("nie_release_bk", {7'h00, bk}, 8'h01);
        tick(2);
        pulse_ig(4'b1000);
        irq = 4'b0000;
        tick(4);

        // Mask keeps a request pending until re-enabled.
        write_mask(4'b1101);
        chk("mask_value", {4'h0, mask}, 8'h0d);
        irq = 4'b0010;
        tick(8);
        chk("mask_pending", {4'h0, pending}, 8'h02);
        exp_q.push_back(2'd1);
        write_mask(4'b1111);
        tick(6);
        chk("mask_served", {4'h0, inservice}, 8'h02);
        pulse_ig(4'b0010);
        irq = 4'b0000;
        tick(4);

        // Masking the armed source drops back to idle with no break.
        hold = 1'b1;
        irq = 4'b1000;
        tick(5);
        chk("cancel_armed_code", {6'h00, code}, 8'h03);
        write_mask(4'b0111);
        hold = 1'b0;
        tick(6);
        chk("cancel_pending", {4'h0, pending}, 8'h08);
        chk("cancel_insvc", {4'h0, inservice}, 8'h00);
        exp_q.push_back(2'd3);
        write_mask(4'b1111);
        tick(6);
        chk("cancel_later_served", {4'h0, inservice}, 8'h08);
        pulse_ig(4'b1000);
        irq = 4'b0000;
        tick(4);

        // Asynchronous reset while armed.
        write_mask(4'b0110);
        hold = 1'b1;
        irq = 4'b0100;
        tick(5);
        chk("reset_armed_code", {6'h00, code}, 8'h02);
        rst = 1'b1;
        irq = 4'b0000;
        #1;
        chk("areset_pending", {4'h0, pending}, 8'h00);
        chk("areset_code", {6'h00, code}, 8'h00);
        chk("areset_bk", {7'h00, bk}, 8'h00);
        chk("areset_mask", {4'h0, mask}, 8'h0f);
        tick(1);
        rst = 1'b0;
        hold = 1'b0;
        tick(10);
        chk("post_reset_pending", {4'h0, pending}, 8'h00);
        chk("post_reset_insvc", {4'h0, inservice}, 8'h00);

        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
